// File: rtl/debounce_event_pkg.sv
// debounce_event_pkg -- default parameters and counter-width helper for debounce_event. Rev 1.0
// Optional hold logic is enabled by defining DEBOUNCE_EVENT_HOLD_EN.
`default_nettype none

package debounce_event_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_N          = 4;
  localparam int DEF_RATE       = 125000;
  localparam int DEF_HOLD_TICKS = 1000;

  // Bits needed to count 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_event_chan.sv
// debounce_event_chan -- one channel: sample history, debounced level, edge pulses, hold. Rev 1.0
// Hold counter is built only when DEBOUNCE_EVENT_HOLD_EN is defined.
`default_nettype none

module debounce_event_chan
  import debounce_event_pkg::*;
#(
  parameter int   N          = DEF_N,
  parameter int   HOLD_TICKS = DEF_HOLD_TICKS,
  parameter logic INIT_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_hold,
  output logic o_hold_pulse
);

  logic [N-1:0] r_hist;
  logic         r_out;
  logic         r_rise;
  logic         r_fall;
  logic         w_out_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= {N{INIT_BIT}};
    end else if (i_tick) begin
      r_hist <= {r_hist[N-2:0], i_sync};
    end
  end

  always_comb begin
    w_out_nxt = r_out;
    if (&r_hist) begin
      w_out_nxt = 1'b1;
    end else if (~|r_hist) begin
      w_out_nxt = 1'b0;
    end
  end

  // Edge pulses are registered with out so they coincide with its transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= INIT_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_out  <= w_out_nxt;
      r_rise <= w_out_nxt & ~r_out;
      r_fall <= ~w_out_nxt & r_out;
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

`ifdef DEBOUNCE_EVENT_HOLD_EN
  localparam int             HW     = clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0]  c_HOLD = HW'(HOLD_TICKS);

  logic [HW-1:0] r_cnt;
  logic [HW-1:0] w_cnt_nxt;
  logic          r_hold;
  logic          r_hold_pulse;

  // Clearing on the next out value lets hold drop on the same edge out falls.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!w_out_nxt) begin
      w_cnt_nxt = '0;
    end else if (i_tick && r_out && (r_cnt != c_HOLD)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_hold       <= 1'b0;
      r_hold_pulse <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_hold       <= (w_cnt_nxt == c_HOLD);
      r_hold_pulse <= (w_cnt_nxt == c_HOLD) & ~r_hold;
    end
  end

  assign o_hold       = r_hold;
  assign o_hold_pulse = r_hold_pulse;
`else
  assign o_hold       = 1'b0;
  assign o_hold_pulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/debounce_event.sv
// debounce_event -- multi-channel synchronizing debouncer with edge and hold events. Rev 1.0
// Hold/hold_pulse are live only when DEBOUNCE_EVENT_HOLD_EN is defined, else tied low.
`default_nettype none

module debounce_event
  import debounce_event_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               N          = DEF_N,
  parameter int               RATE       = DEF_RATE,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int               HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold,
  output logic [WIDTH-1:0] hold_pulse
);

  localparam int                CNT_W  = clog2(RATE);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(RATE - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [CNT_W-1:0] r_presc;
  logic             w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= INIT;
      r_sync2 <= INIT;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_event_chan #(
      .N          (N),
      .HOLD_TICKS (HOLD_TICKS),
      .INIT_BIT   (INIT[i])
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_tick       (w_tick),
      .i_sync       (r_sync2[i]),
      .o_out        (out[i]),
      .o_rise       (rise[i]),
      .o_fall       (fall[i]),
      .o_hold       (hold[i]),
      .o_hold_pulse (hold_pulse[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_event.sv
// tb_debounce_event -- directed self-checking bench for debounce_event (WIDTH=4, N=4, RATE=8, HOLD_TICKS=16).
`default_nettype none

module tb_debounce_event;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic [3:0] din2;
  logic [3:0] out, rise, fall, hold, hold_pulse;
  logic [3:0] out2, rise2, fall2, hold2, hold_pulse2;

  int vec;
  int miss;
  int bad2;

  debounce_event #(
    .WIDTH(4), .N(4), .RATE(8), .INIT(4'b0000), .HOLD_TICKS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .out(out), .rise(rise), .fall(fall),
    .hold(hold), .hold_pulse(hold_pulse)
  );

  debounce_event #(
    .WIDTH(4), .N(4), .RATE(8), .INIT(4'b1111), .HOLD_TICKS(16)
  ) dut_init1 (
    .clk(clk), .rst_n(rst_n), .in(din2), .out(out2), .rise(rise2), .fall(fall2),
    .hold(hold2), .hold_pulse(hold_pulse2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // INIT=1 instance sees in=1 throughout; it must never pulse or drop out.
  always @(negedge clk) begin
    if (rst_n && (rise2 != 4'h0 || fall2 != 4'h0 || out2 != 4'hF)) bad2++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    din   = 4'h0;
    din2  = 4'hF;
    step(3);
    vec++;
    if ({out, rise, fall, hold, hold_pulse} !== 20'h0) begin
      miss++;
      $display("FAIL reset_state: got %h expected 00000", {out, rise, fall, hold, hold_pulse});
    end
    vec++;
    if ({out2, rise2, fall2} !== 12'hF00) begin
      miss++;
      $display("FAIL reset_init1: got %h expected f00", {out2, rise2, fall2});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (out2 !== 4'hF || rise2 !== 4'h0 || fall2 !== 4'h0) bad++;
      if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) bad++;
    end
    vec++;
    if (bad !== 0) begin
      miss++;
      $display("FAIL post_release_quiet: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_single_rise();
    int lat, rcnt;
    lat  = -1;
    rcnt = 0;
    din[0] = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step(1);
      if (rise[0]) rcnt++;
      if (out[0] && lat < 0) begin
        lat = c;
        vec++;
        if (rise[0] !== 1'b1) begin
          miss++;
          $display("FAIL rise_align: got rise=%b expected 1", rise[0]);
        end
      end
    end
    // Earliest sample edge is 3 (sync), latest first tick is edge 10.
    vec++;
    if (lat < 28 || lat > 35) begin
      miss++;
      $display("FAIL rise_latency: got %0d expected 28..35", lat);
    end
    vec++;
    if (rcnt !== 1) begin
      miss++;
      $display("FAIL rise_count: got %0d expected 1", rcnt);
    end
    vec++;
    if (out[3:1] !== 3'b000) begin
      miss++;
      $display("FAIL channel_isolation: got %b expected 000", out[3:1]);
    end
  endtask

  task automatic test_fall();
    int fcnt, rcnt;
    bit seen;
    fcnt = 0;
    rcnt = 0;
    seen = 0;
    din[0] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step(1);
      if (fall[0]) fcnt++;
      if (rise[0]) rcnt++;
      if (!out[0] && !seen) begin
        seen = 1;
        vec++;
        if (fall[0] !== 1'b1 || c > 35) begin
          miss++;
          $display("FAIL fall_align: got fall=%b at %0d expected 1 within 35", fall[0], c);
        end
      end
    end
    vec++;
    if (!seen || fcnt !== 1 || rcnt !== 0) begin
      miss++;
      $display("FAIL fall_count: got seen=%0d fall=%0d rise=%0d expected 1 1 0", seen, fcnt, rcnt);
    end
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (c % 10 == 0) din[1] = ~din[1];
      step(1);
      if (out[1] || rise[1] || fall[1]) bad++;
    end
    din[1] = 1'b0;
    step(40);
    vec++;
    if (bad !== 0 || out[1] !== 1'b0) begin
      miss++;
      $display("FAIL bounce_reject: got %0d bad cycles out=%b expected 0 0", bad, out[1]);
    end
  endtask

  task automatic test_hold();
    int  t_out, t_hold, hp, bad;
    bit  prev_hold, fell;
    t_out  = -1;
    t_hold = -1;
    hp     = 0;
    bad    = 0;
    din[2] = 1'b1;
    for (int c = 1; c <= 1600; c++) begin
      step(1);
      if (out[2] && t_out < 0) t_out = c;
      if (hold_pulse[2]) hp++;
      if (hold[2] && t_hold < 0) begin
        t_hold = c;
        vec++;
        if (hold_pulse[2] !== 1'b1) begin
          miss++;
          $display("FAIL hold_pulse_align: got %b expected 1", hold_pulse[2]);
        end
      end
`ifndef DEBOUNCE_EVENT_HOLD_EN
      if (hold !== 4'h0 || hold_pulse !== 4'h0) bad++;
`endif
    end
`ifdef DEBOUNCE_EVENT_HOLD_EN
    // Counter starts on the first tick after out rises: 16 ticks later minus one cycle.
    vec++;
    if (t_out < 0 || t_hold < 0 || (t_hold - t_out) !== 127) begin
      miss++;
      $display("FAIL hold_delay: got out@%0d hold@%0d expected gap 127", t_out, t_hold);
    end
    vec++;
    if (hp !== 1 || hold[2] !== 1'b1) begin
      miss++;
      $display("FAIL hold_pulse_count: got %0d hold=%b expected 1 1", hp, hold[2]);
    end
`else
    vec++;
    if (bad !== 0 || hp !== 0 || t_out < 0) begin
      miss++;
      $display("FAIL hold_tied_off: got %0d bad cycles, out@%0d expected 0 and rise", bad, t_out);
    end
`endif
    din[2]    = 1'b0;
    prev_hold = hold[2];
    fell      = 0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (!out[2]) begin
        fell = 1;
        vec++;
`ifdef DEBOUNCE_EVENT_HOLD_EN
        if (fall[2] !== 1'b1 || hold[2] !== 1'b0 || hold_pulse[2] !== 1'b0 || prev_hold !== 1'b1) begin
`else
        if (fall[2] !== 1'b1 || hold[2] !== 1'b0 || hold_pulse[2] !== 1'b0) begin
`endif
          miss++;
          $display("FAIL hold_release: got fall=%b hold=%b hp=%b prev=%b expected 1 0 0 held",
                   fall[2], hold[2], hold_pulse[2], prev_hold);
        end
        break;
      end
      prev_hold = hold[2];
    end
    vec++;
    if (!fell) begin
      miss++;
      $display("FAIL hold_release_timeout: got out=%b expected 0", out[2]);
    end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    din   = 4'b0111;
    step(1);
    rst_n = 1'b1;
    // Ticks fall on edges 8,16,24,32 after release; out follows on edge 33.
    step(32);
    vec++;
    if (out !== 4'h0) begin
      miss++;
      $display("FAIL aligned_pre: got %b expected 0000", out);
    end
    step(1);
    vec++;
    if (out !== 4'b0111 || rise !== 4'b0111) begin
      miss++;
      $display("FAIL aligned_rise: got out=%b rise=%b expected 0111 0111", out, rise);
    end
    step(7);
    din = 4'hF;
    step(26);
    rst_n = 1'b0;
    #1;
    vec++;
    if ({out, rise, fall, hold, hold_pulse} !== 20'h0 || out2 !== 4'hF) begin
      miss++;
      $display("FAIL mid_reset_clear: got %h out2=%b expected 00000 1111",
               {out, rise, fall, hold, hold_pulse}, out2);
    end
    step(2);
    rst_n = 1'b1;
    step(32);
    vec++;
    if (out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
      miss++;
      $display("FAIL restart_window: got out=%b rise=%b fall=%b expected 0000 0000 0000", out, rise, fall);
    end
    step(1);
    vec++;
    if (out !== 4'hF || rise !== 4'hF) begin
      miss++;
      $display("FAIL simultaneous_rise: got out=%b rise=%b expected 1111 1111", out, rise);
    end
    step(1);
    vec++;
    if (rise !== 4'h0 || out !== 4'hF) begin
      miss++;
      $display("FAIL rise_width: got rise=%b out=%b expected 0000 1111", rise, out);
    end
  endtask

  task automatic test_fall_together();
    bit seen;
    seen = 0;
    din  = 4'h0;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (out !== 4'hF) begin
        seen = 1;
        vec++;
        if (out !== 4'h0 || fall !== 4'hF || rise !== 4'h0) begin
          miss++;
          $display("FAIL simultaneous_fall: got out=%b fall=%b rise=%b expected 0000 1111 0000", out, fall, rise);
        end
        break;
      end
    end
    step(1);
    vec++;
    if (!seen || fall !== 4'h0) begin
      miss++;
      $display("FAIL fall_width: got seen=%0d fall=%b expected 1 0000", seen, fall);
    end
  endtask

  initial begin
    vec  = 0;
    miss = 0;
    bad2 = 0;
    rst_n = 1'b0;
    din   = 4'h0;
    din2  = 4'hF;
    test_reset();
    test_single_rise();
    test_fall();
    test_bounce();
    test_hold();
    test_mid_reset();
    test_fall_together();
    vec++;
    if (bad2 !== 0) begin
      miss++;
      $display("FAIL init1_quiet: got %0d bad cycles expected 0", bad2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/debounce_event.md
DEBOUNCE_EVENT -- requirements
Module: debounce_event

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: number of independent input channels.
REQ-002 SHALL provide parameter N, default 4: samples in the stability window, minimum 2.
REQ-003 SHALL provide parameter RATE, default 125000: clk cycles per sample tick, minimum 1.
REQ-004 SHALL provide parameter INIT, default {WIDTH{1'b0}}: per-channel reset level of out and the sample history.
REQ-005 SHALL provide parameter HOLD_TICKS, default 1000: sample ticks of stable high before hold asserts, minimum 1.
REQ-006 SHALL provide port clk, input, 1: the single clock for all logic.
REQ-007 SHALL provide port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL provide port in, input, WIDTH: raw asynchronous switch and button levels.
REQ-009 SHALL provide port out, output, WIDTH: debounced levels.
REQ-010 SHALL provide port rise, output, WIDTH: one-cycle pulse on a debounced 0->1 transition.
REQ-011 SHALL provide port fall, output, WIDTH: one-cycle pulse on a debounced 1->0 transition.
REQ-012 SHALL provide port hold, output, WIDTH: level, channel has been debounced-high for at least HOLD_TICKS ticks.
REQ-013 SHALL provide port hold_pulse, output, WIDTH: one-cycle pulse on the cycle hold rises.

Function
REQ-014 SHALL pass each in bit through a 2-flop synchronizer before any use.
REQ-015 SHALL run one shared prescaler counter 0..RATE-1 that asserts tick for one cycle at RATE-1 and wraps to 0; RATE=1 SHALL assert tick every cycle.
REQ-016 SHALL, on tick only, shift the synchronized bit into each channel's N-bit history.
REQ-017 SHALL set out high one cycle after the history becomes all ones, set it low one cycle after it becomes all zeros, and otherwise hold out.
REQ-018 SHALL assert rise (fall) in exactly the cycle out goes 0->1 (1->0), never both, never for more than one cycle.
REQ-019 SHALL keep a per-channel hold counter that increments on each tick while out=1, saturates at HOLD_TICKS, and clears in the cycle out=0.
REQ-020 SHALL assert hold while the counter equals HOLD_TICKS, and pulse hold_pulse once per high episode in the cycle hold rises.
REQ-021 SHALL deassert hold in the same cycle out falls, with no pulse on that transition.
REQ-022 SHALL give worst-case latency from an in edge to out of 2 + N*RATE + 1 clk cycles.
REQ-023 SHALL treat every channel independently; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force: prescaler=0, synchronizers=INIT, histories all bits=INIT, out=INIT, rise=0, fall=0, hold counters=0, hold=0, hold_pulse=0.
REQ-025 SHALL produce no rise, fall or hold_pulse pulse on the first cycle after rst_n releases, including when INIT=1; mid-operation reset SHALL abandon partial windows.

Configuration
REQ-026 SHALL compile hold logic only when macro DEBOUNCE_EVENT_HOLD_EN is defined.
REQ-027 SHALL, without DEBOUNCE_EVENT_HOLD_EN, tie hold and hold_pulse to 0 and instantiate no hold counters; all other behaviour SHALL be unchanged.

Structure
REQ-028 SHALL put default parameter values and the counter-width helper (clog2) in package debounce_event_pkg.
REQ-029 SHALL implement per-channel history, out, edge and hold logic in sub-module debounce_event_chan, generated WIDTH times and fed the shared tick.

Verification (WIDTH=4, N=4, RATE=8, HOLD_TICKS=16, INIT=0 unless stated)
REQ-030 SHALL drive in[0] 0->1 and hold it -> out[0]=1 within 2+32+1 cycles, with rise[0] high for exactly 1 cycle.
REQ-031 SHALL toggle in[1] every 10 cycles for 400 cycles -> out[1] stays 0, with no rise or fall pulse.
REQ-032 SHALL hold in[2]=1 for 200 ticks -> hold[2] rises 16 ticks after out[2] rises, with a single hold_pulse; release -> hold[2] and out[2] fall together and fall[2] pulses.
REQ-033 SHALL drive in=4'b1111 in one cycle -> out bits rise in the same cycle and rise=4'b1111 for 1 cycle.
REQ-034 SHALL assert rst_n=0 mid-window with in[3]=1 and 3 samples taken -> all outputs 0 immediately; after release, out[3] again needs 4 full ticks.
REQ-035 SHALL reset with INIT=4'b1111 and in=4'b1111 -> out=4'b1111 from reset, with no rise pulse after release.
